// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU port (0) and the loader/debug port (1).
// Optional feature macro DMEM_ARB_RR_EN: round-robin on ties; undefined gives fixed priority to port 0.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // state  | meaning
  // IDLE   | arbitrate pending requests, latch the winner into the mem_* registers
  // ACCESS | memory cycle; mem_we high for writes, read data captured at its closing edge
  // RESP   | one-cycle ack to the granted port

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   grant;
  logic   we_q;
  logic   any_req;
  logic   pick;

`ifdef DMEM_ARB_RR_EN
  logic last_grant;

  always_comb begin
    any_req = m0_req | m1_req;
    pick    = (m0_req & m1_req) ? ~last_grant : m1_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_grant <= pick;
    end
  end
`else
  always_comb begin
    any_req = m0_req | m1_req;
    pick    = ~m0_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode straight from state so an async reset drops mem_we and acks at once.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_we    = we_q;
        state_nxt = RESP;
      end
      RESP: begin
        m0_ack    = ~grant;
        m1_ack    = grant;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      grant     <= pick;
      we_q      <= pick ? m1_we    : m0_we;
      mem_addr  <= pick ? m1_addr  : m0_addr;
      mem_wdata <= pick ? m1_wdata : m0_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == ACCESS && !we_q) begin
      if (grant) begin
        m1_rdata <= mem_rdata;
      end else begin
        m0_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between two requesters: port 0 is the CPU load/store path and port 1 is the loader/debug path. It accepts request/acknowledge transactions, serialises them onto the memory's address, write-data and write-enable signals, and returns read data with a one-cycle acknowledge. It sits between the core and the data memory, taking the place of the direct register-file-to-memory wiring.

## Interface
- AW, default 32: address width on both ports and on the memory side.
- DW, default 32: data width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  request. Held high with stable we/addr/wdata until ack.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  AW  byte address, passed through unmodified.
- m0_wdata, m1_wdata  in  DW  write data.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  DW  read data. Valid while ack is high and held until that port's next ack.
- mem_addr  out  AW  memory address. Registered.
- mem_wdata  out  DW  memory write data. Registered.
- mem_we  out  1  memory write enable. High only in ACCESS for a write.
- mem_rdata  in  DW  combinational read data from memory for mem_addr.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: arbitrate; if any req is high, latch the winner's we/addr/wdata into the mem_* registers, record the grant, and go to ACCESS.
  - ACCESS: mem_we = latched we. Sample mem_rdata at the rising edge that ends the cycle, into the granted port's rdata register (reads only). Go to RESP.
  - RESP: assert the granted port's ack for exactly one cycle. Go to IDLE.
- Requests are ignored outside IDLE. A req still high during RESP is treated as a new request in the following IDLE cycle.
- Arbitration when both req are high follows Configuration.
- Write with DW data: rdata of that port is unchanged.
- Reset values: state IDLE; m0_ack=m1_ack=0; m0_rdata=m1_rdata=0; mem_addr=0; mem_wdata=0; mem_we=0; busy=0; last_grant=1.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronous), including a mem_we that was high in ACCESS. No ack is issued. The requester keeps req high and is re-served after reset is released.
- A requester dropping req before its ack is a protocol violation. The transaction still completes and acks.

## Timing
- Latency: req seen high in IDLE at edge N; ACCESS during cycle N+1; ack high during cycle N+2; IDLE again at N+3.
- Throughput: one access per 3 cycles. Back-to-back requests from the same port complete every 3 cycles.
- mem_we is a single-cycle pulse aligned with ACCESS. The memory writes at the edge ending ACCESS.
- m0_ack and m1_ack are never high in the same cycle.
- mem_addr and mem_wdata hold their last values after the transaction ends. They are not cleared in IDLE.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the port not recorded in last_grant.
  - last_grant updates on every grant.
  - Reset value 1, so port 0 wins the first tie.
- DMEM_ARB_RR_EN undefined: fixed priority. Port 0 always wins ties and last_grant is unused. Port 1 can starve under continuous port-0 requests; this is accepted behaviour.

## Test plan
- Single write then read, port 0:
  - Write 0x0000_0010 ← 0xDEAD_BEEF: mem_we high exactly one cycle (cycle 2 after req), m0_ack pulses in cycle 3.
  - Read of 0x10: m0_rdata = 0xDEAD_BEEF during ack.
- Simultaneous requests, both ports reading distinct preloaded addresses:
  - With DMEM_ARB_RR_EN: port 0 acked first, port 1 acked 3 cycles later.
  - Repeating the tie four times gives alternating acks 0,1,0,1.
  - Without the macro: under continuous m0_req, m1_ack never asserts over 30 cycles.
- Back-to-back: port 1 holds req high for 4 reads of 0x0, 0x4, 0x8, 0xC (address changed after each ack) → 4 acks spaced exactly 3 cycles apart, rdata matching memory.
- Reset mid-write: assert rst_n=0 during ACCESS of a port-0 write → mem_we falls without waiting for a clock edge, no ack. After release with req held, the write completes and ack appears 2 cycles after the first IDLE edge.
- Port isolation: port 0 reads 0x20 (value 0x1234_5678), then port 1 writes → m0_rdata still 0x1234_5678. busy low in every IDLE cycle and high otherwise.
